counter_controller: RTL and testbench
=====================================

Name: counter_controller

Overview:
- Control FSM that sits directly upstream of `counter_datapath` and drives its control inputs.
- Together the two blocks form the bit-count (population count) unit: the datapath loads A, shifts it right and counts ones; this block sequences load/clear/shift/increment/done from a user start request.
- It observes the datapath's `A_out` to decide when to increment and when to stop.
- It also provides a synchronised start input and busy/result-valid status for the display/top level.

Parameters:
- WIDTH, 8, width of the operand A; must match the datapath.
- SYNC_STAGES, 2, number of flops in the start synchroniser (minimum 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  asynchronous level request from switch/key; high = run.
- A_out  input  WIDTH  current A register value from the datapath.
- clear_result  output  1  datapath: clear count and result.
- load_a  output  1  datapath: load A from A_in.
- right_shift  output  1  datapath: A <= A >> 1.
- incr  output  1  datapath: count <= count + 1.
- done  output  1  datapath: result <= count; single-cycle pulse.
- busy  output  1  high while in S_COUNT.
- result_valid  output  1  high while in S_DONE; the result is stable.

Behaviour:
- Start synchroniser:
  - SYNC_STAGES flops, all reset to 0; `start_s` is the last stage.
  - FSM sees a start change SYNC_STAGES cycles after the pin changes.
- States: S_IDLE, S_COUNT, S_DONE. Encoding is free; reset state is S_IDLE, entered asynchronously when reset=0.
- S_IDLE:
  - Outputs: clear_result=1, load_a=1 (A tracks A_in every cycle), all others 0.
  - Transition: start_s=1 -> S_COUNT; otherwise stay.
  - The last load occurs in the cycle that sees start_s=1, so A holds the input sampled in that cycle.
- S_COUNT:
  - busy=1.
  - If A_out==0: done=1, right_shift=0, incr=0; next state S_DONE.
  - Else: right_shift=1, incr=A_out[0], done=0; stay in S_COUNT.
  - done is only asserted once A_out==0, i.e. after the final incr has already landed, so the datapath captures the complete count.
- S_DONE:
  - result_valid=1; all datapath controls 0.
  - Stay while start_s=1; start_s=0 -> S_IDLE.
  - Result is held because clear_result is not asserted until back in S_IDLE.
- Outputs are pure functions of state and A_out. No registered outputs, so reset values follow from S_IDLE: clear_result=1, load_a=1, every other output 0.
- Latency:
  - Let h be the index of the highest set bit of A. S_COUNT lasts h+2 cycles: h+1 shifts plus one done cycle.
  - A==0 gives exactly 1 cycle (the done cycle).
  - Worst case is WIDTH+1 cycles.
- Boundary conditions:
  - start held high after completion: no restart until start_s has returned to 0 and gone high again.
  - start dropped during S_COUNT: ignored; the count runs to completion, then S_DONE exits on the next cycle.
  - reset asserted mid-count: immediate return to S_IDLE; clear_result/load_a take effect on the next clock, and no done pulse is issued.
  - A_out is never shifted past zero. right_shift and done are mutually exclusive; incr never fires with done.
- Invariant: done is high for exactly one cycle per run.

Test Plan:
- Reset, A_in=0x00, raise start: S_COUNT lasts 1 cycle with done=1 -> result=0, result_valid high, no incr pulses.
- A_in=0x05, start: 3 shift cycles with incr pattern 1,0,1, then done -> result=2, busy high for 4 cycles.
- A_in=0xFF: 8 shift cycles with incr each cycle, then done -> result=8 (datapath result width permitting), busy 9 cycles. A_in=0x80: 8 shifts, a single incr on the last, done -> result=1.
- Start held high 20 cycles after done: FSM stays in S_DONE with result unchanged. Drop start, change A_in to 0x03, raise start -> new result=2.
- Drop start 2 cycles into a 0xFF run: the run completes with result=8, then S_IDLE one cycle after S_DONE is reached.
- Assert reset during cycle 4 of a 0xF0 run: outputs return immediately to the S_IDLE values, no done pulse. Release reset and rerun 0xF0 -> result=4.

Source files
------------

// File: rtl/counter_controller.sv
// Sequencing FSM for the population-count unit: synchronises the start request
// and drives load/clear/shift/incr/done into counter_datapath from its A_out.
module counter_controller #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A_out,
  output logic             clear_result,
  output logic             load_a,
  output logic             right_shift,
  output logic             incr,
  output logic             done,
  output logic             busy,
  output logic             result_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_start_s;
  logic                   w_a_zero;

  assign w_start_s = r_sync[SYNC_STAGES-1];
  assign w_a_zero  = (A_out == '0);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], start};
    end
  end

  // A run always completes; a dropped start is only acted on from S_DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_start_s)  r_state <= S_COUNT;
        S_COUNT: if (w_a_zero)   r_state <= S_DONE;
        S_DONE:  if (!w_start_s) r_state <= S_IDLE;
        default:                 r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    clear_result = 1'b0;
    load_a       = 1'b0;
    right_shift  = 1'b0;
    incr         = 1'b0;
    done         = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        clear_result = 1'b1;
        load_a       = 1'b1;
      end
      S_COUNT: begin
        busy = 1'b1;
        // done waits for A to reach zero, so the last incr has already landed.
        if (w_a_zero) begin
          done = 1'b1;
        end else begin
          right_shift = 1'b1;
          incr        = A_out[0];
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
      end
      default: begin
        clear_result = 1'b1;
        load_a       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_controller.sv
// Bench for counter_controller: a behavioural datapath closes the loop, and each
// run is checked against popcount / highest-set-bit expectations.
module tb_counter_controller;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] A_out;
  logic             clear_result, load_a, right_shift, incr, done, busy, result_valid;

  logic [WIDTH-1:0] a_in;
  logic [7:0]       count_q;
  logic [7:0]       result_q;

  int n_checks = 0;
  int n_fail   = 0;

  counter_controller #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .A_out        (A_out),
    .clear_result (clear_result),
    .load_a       (load_a),
    .right_shift  (right_shift),
    .incr         (incr),
    .done         (done),
    .busy         (busy),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: loads/shifts A, counts ones, captures result on done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A_out    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      if (load_a)           A_out <= a_in;
      else if (right_shift) A_out <= A_out >> 1;
      if (clear_result) begin
        count_q  <= '0;
        result_q <= '0;
      end else begin
        if (incr) count_q  <= count_q + 8'd1;
        if (done) result_q <= count_q;
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({clear_result, load_a, right_shift, incr, done, busy, result_valid} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL %s: outputs {clr,ld,shr,inc,done,busy,rv}=%b required 1100000", name,
               {clear_result, load_a, right_shift, incr, done, busy, result_valid});
    end
  endtask

  // One full run of operand a. drop_at >= 0 drops start in that busy cycle;
  // otherwise start is held for `hold` cycles after completion before release.
  task automatic run(input logic [WIDTH-1:0] a, input int drop_at, input int hold);
    int h, exp_pc, exp_cyc, lat, cyc, n_done, n_incr, k;
    logic exp_shift, exp_inc, exp_done;
    bit stable;
    h = -1;
    exp_pc = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) begin
        exp_pc++;
        h = i;
      end
    end
    exp_cyc = h + 2;

    a_in  = a;
    start = 1'b1;
    lat   = 0;
    while (!busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== SYNC_STAGES + 1) begin
      n_fail++;
      $display("FAIL start_latency a=%h: busy after %0d cycles, required %0d", a, lat, SYNC_STAGES + 1);
    end
    n_checks++;
    if (A_out !== a) begin
      n_fail++;
      $display("FAIL loaded_a: A=%h required %h", A_out, a);
    end

    cyc = 0;
    n_done = 0;
    n_incr = 0;
    while (busy && cyc < 40) begin
      if (cyc == drop_at) start = 1'b0;
      k = cyc;
      exp_shift = (k <= h);
      exp_inc   = (k <= h) ? a[k] : 1'b0;
      exp_done  = (k == h + 1);
      n_checks++;
      if ({right_shift, incr, done} !== {exp_shift, exp_inc, exp_done}) begin
        n_fail++;
        $display("FAIL count_cycle a=%h cyc=%0d: {shr,inc,done}=%b required %b", a, cyc,
                 {right_shift, incr, done}, {exp_shift, exp_inc, exp_done});
      end
      if (done) n_done++;
      if (incr) n_incr++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL busy_cycles a=%h: %0d required %0d", a, cyc, exp_cyc);
    end
    n_checks++;
    if (n_done !== 1 || n_incr !== exp_pc) begin
      n_fail++;
      $display("FAIL pulse_counts a=%h: done=%0d incr=%0d required done=1 incr=%0d", a, n_done, n_incr, exp_pc);
    end
    n_checks++;
    if (result_valid !== 1'b1 || result_q !== 8'(exp_pc) ||
        {clear_result, load_a, right_shift, incr, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL result a=%h: rv=%b result=%0d ctrl=%b required rv=1 result=%0d ctrl=00000", a,
               result_valid, result_q, {clear_result, load_a, right_shift, incr, done}, exp_pc);
    end

    if (drop_at >= 0) begin
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || clear_result !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_exit a=%h: rv=%b clr=%b required rv=0 clr=1", a, result_valid, clear_result);
      end
    end else begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (result_valid !== 1'b1 || busy !== 1'b0 || result_q !== 8'(exp_pc)) stable = 1'b0;
      end
      if (hold > 0) begin
        n_checks++;
        if (!stable) begin
          n_fail++;
          $display("FAIL hold_done a=%h: left S_DONE or result changed, required stable result %0d", a, exp_pc);
        end
      end
      start = 1'b0;
      lat = 0;
      while (result_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat !== SYNC_STAGES + 1) begin
        n_fail++;
        $display("FAIL release_latency a=%h: idle after %0d cycles, required %0d", a, lat, SYNC_STAGES + 1);
      end
    end
    check_idle_outputs("back_to_idle");
    @(negedge clk);
    n_checks++;
    if (result_q !== 8'd0) begin
      n_fail++;
      $display("FAIL result_cleared: result=%0d required 0", result_q);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    a_in  = '0;
    #1;
    check_idle_outputs("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle_without_start");
  endtask

  task automatic test_patterns;
    run(8'h00, -1, 0);
    run(8'h05, -1, 0);
    run(8'hFF, -1, 0);
    run(8'h80, -1, 0);
  endtask

  task automatic test_hold_start;
    run(8'h05, -1, 20);
    run(8'h03, -1, 0);
  endtask

  task automatic test_drop_start;
    run(8'hFF, 2, 0);
  endtask

  task automatic test_reset_mid_count;
    int lat;
    bit saw_done;
    a_in  = 8'hF0;
    start = 1'b1;
    lat   = 0;
    while (!busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (!busy) begin
      n_fail++;
      $display("FAIL mid_reset_start: busy=%b required 1", busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_mid_count");
    start = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL no_done_in_reset: done seen=1 required 0");
    end
    reset = 1'b1;
    @(negedge clk);
    run(8'hF0, -1, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      run(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), -1, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_hold_start();
    test_drop_start();
    test_reset_mid_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
